// File: rtl/lock_timer_pkg.sv
// Shared definitions for the code-lock timing blocks: state encodings,
// default timing parameters and a parameter range helper.
package lock_timer_pkg;

    // FSM state encodings (binary, 2 bits)
    localparam logic [1:0] ST_LOCKED  = 2'd0;
    localparam logic [1:0] ST_OPEN    = 2'd1;
    localparam logic [1:0] ST_PENALTY = 2'd2;

    // Defaults shared with the keypad and display blocks
    localparam int DEF_OPEN_S    = 5;
    localparam int DEF_PENALTY_S = 10;
    localparam int DEF_MAX_FAIL  = 3;
    localparam int DEF_CNT_W     = 8;

    // Width of the consecutive-failure counter
    localparam int FAIL_W = 4;

    // True when v is nonzero and representable in an unsigned w-bit field
    function automatic bit fits_nonzero(input int v, input int w);
        longint unsigned max_v;
        max_v = (longint'(1) << w) - 1;
        return (v >= 1) && (longint'(v) <= longint'(max_v));
    endfunction

endpackage

// File: rtl/lock_timer_sec_downcounter.sv
// Seconds down-counter used for the open window and the penalty lockout.
// Load has priority over decrement; the count never wraps below zero.
module sec_downcounter
    import lock_timer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [CNT_W-1:0] load_val,
    input  logic             load,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             is_one
);

    logic [CNT_W-1:0] one_val;
    logic             at_zero;

    assign one_val = {{(CNT_W-1){1'b0}}, 1'b1};
    assign at_zero = (count == '0);
    assign is_one  = (count == one_val);

    // Count register: async clear, synchronous load, guarded decrement
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !at_zero) begin
            count <= count - one_val;
        end
    end

endmodule

// File: rtl/lock_timer.sv
// Seconds-domain timing FSM for the code lock. Consumes the 1 s prescaler
// strobe as tick, takes verdict pulses from the code comparator, drives the
// bolt for a timed open window and enforces a timed lockout after MAX_FAIL
// consecutive wrong codes. All outputs are registered (one clock latency).
module lock_timer
    import lock_timer_pkg::*;
#(
    parameter int OPEN_S    = DEF_OPEN_S,
    parameter int PENALTY_S = DEF_PENALTY_S,
    parameter int MAX_FAIL  = DEF_MAX_FAIL,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              tick,
    input  logic              code_ok,
    input  logic              code_bad,
    input  logic              relock,
    output logic              unlock,
    output logic              blocked,
    output logic              alarm,
    output logic [CNT_W-1:0]  sec_left,
    output logic [FAIL_W-1:0] fail_cnt
);

    // Parameter sanity: reject configurations that cannot work
    if (!fits_nonzero(OPEN_S, CNT_W)) begin : g_bad_open_s
        $error("lock_timer: OPEN_S must be nonzero and fit in CNT_W bits");
    end
    if (!fits_nonzero(PENALTY_S, CNT_W)) begin : g_bad_penalty_s
        $error("lock_timer: PENALTY_S must be nonzero and fit in CNT_W bits");
    end
    if (MAX_FAIL < 1 || MAX_FAIL > 15) begin : g_bad_max_fail
        $error("lock_timer: MAX_FAIL must be in 1..15");
    end

    localparam logic [CNT_W-1:0]  OPEN_LOAD    = CNT_W'(OPEN_S);
    localparam logic [CNT_W-1:0]  PENALTY_LOAD = CNT_W'(PENALTY_S);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT   = FAIL_W'(MAX_FAIL);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [FAIL_W-1:0] fail_nxt;
    logic [FAIL_W-1:0] fail_inc;
    logic [CNT_W-1:0]  load_val;
    logic              load;
    logic              dec;
    logic              is_one;

    assign fail_inc = fail_cnt + FAIL_W'(1);

    // Next-state, counter control and failure bookkeeping
    always_comb begin
        state_nxt = state;
        fail_nxt  = fail_cnt;
        load_val  = '0;
        load      = 1'b0;
        dec       = 1'b0;
        case (state)
            ST_LOCKED: begin
                // code_bad wins over a simultaneous code_ok
                if (code_bad) begin
                    if (fail_inc == FAIL_LIMIT) begin
                        state_nxt = ST_PENALTY;
                        load_val  = PENALTY_LOAD;
                        load      = 1'b1;
                        fail_nxt  = '0;
                    end else begin
                        fail_nxt  = fail_inc;
                    end
                end else if (code_ok) begin
                    state_nxt = ST_OPEN;
                    load_val  = OPEN_LOAD;
                    load      = 1'b1;
                    fail_nxt  = '0;
                end
            end
            ST_OPEN: begin
                fail_nxt = '0;
                // relock beats a tick in the same cycle
                if (relock) begin
                    state_nxt = ST_LOCKED;
                    load      = 1'b1;
                end else if (tick) begin
                    dec = 1'b1;
                    if (is_one) begin
                        state_nxt = ST_LOCKED;
                    end
                end
            end
            ST_PENALTY: begin
                fail_nxt = '0;
                if (tick) begin
                    dec = 1'b1;
                    if (is_one) begin
                        state_nxt = ST_LOCKED;
                    end
                end
            end
            default: begin
                // Unused encoding: recover to a safe locked state
                state_nxt = ST_LOCKED;
                load      = 1'b1;
                fail_nxt  = '0;
            end
        endcase
    end

    // State, failure counter and registered status outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= ST_LOCKED;
            fail_cnt <= '0;
            unlock   <= 1'b0;
            blocked  <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            state    <= state_nxt;
            fail_cnt <= fail_nxt;
            unlock   <= (state_nxt == ST_OPEN);
            blocked  <= (state_nxt == ST_PENALTY);
            alarm    <= (state_nxt == ST_PENALTY) && (state != ST_PENALTY);
        end
    end

    sec_downcounter #(
        .CNT_W (CNT_W)
    ) u_sec_cnt (
        .clk      (clk),
        .clr      (clr),
        .load_val (load_val),
        .load     (load),
        .dec      (dec),
        .count    (sec_left),
        .is_one   (is_one)
    );

endmodule

// File: tb/tb_lock_timer.sv
// Directed bench for lock_timer with default parameters
// (OPEN_S=5, PENALTY_S=10, MAX_FAIL=3, CNT_W=8).
module tb_lock_timer;

    logic       clk = 1'b0;
    logic       clr;
    logic       tick;
    logic       code_ok;
    logic       code_bad;
    logic       relock;
    logic       unlock;
    logic       blocked;
    logic       alarm;
    logic [7:0] sec_left;
    logic [3:0] fail_cnt;

    int checks = 0;
    int errors = 0;

    lock_timer dut (
        .clk      (clk),
        .clr      (clr),
        .tick     (tick),
        .code_ok  (code_ok),
        .code_bad (code_bad),
        .relock   (relock),
        .unlock   (unlock),
        .blocked  (blocked),
        .alarm    (alarm),
        .sec_left (sec_left),
        .fail_cnt (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present inputs for one active edge, then sample 1 time unit after it
    task automatic cyc(input logic t, input logic ok, input logic bad, input logic rel);
        tick = t; code_ok = ok; code_bad = bad; relock = rel;
        @(posedge clk);
        #1;
        tick = 1'b0; code_ok = 1'b0; code_bad = 1'b0; relock = 1'b0;
    endtask

    task automatic chk_all(input string tag, input int u, input int b, input int a,
                           input int s, input int f);
        chk({tag, ".unlock"},   int'(unlock),   u);
        chk({tag, ".blocked"},  int'(blocked),  b);
        chk({tag, ".alarm"},    int'(alarm),    a);
        chk({tag, ".sec_left"}, int'(sec_left), s);
        chk({tag, ".fail_cnt"}, int'(fail_cnt), f);
    endtask

    initial begin
        clr = 1'b0; tick = 1'b0; code_ok = 1'b0; code_bad = 1'b0; relock = 1'b0;

        // Reset asserted between edges takes effect without a clock
        #3 clr = 1'b1;
        #1 chk_all("rst_async", 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0);
            repeat (3) cyc(0, 0, 0, 0);
        end
        chk_all("idle_ticks", 0, 0, 0, 0, 0);

        // Open window runs for exactly five ticks; codes ignored while open
        cyc(0, 1, 0, 0);
        chk_all("open_entry", 1, 0, 0, 5, 0);
        cyc(0, 0, 1, 0);
        chk_all("open_bad_ignored", 1, 0, 0, 5, 0);
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 0, 0, 0);
            chk("open_tick.sec_left", int'(sec_left), 5 - i);
            chk("open_tick.unlock", int'(unlock), (i < 5) ? 1 : 0);
            if (i < 5) begin
                repeat (3) cyc(0, 0, 0, 0);
                chk("open_hold.sec_left", int'(sec_left), 5 - i);
            end
        end
        cyc(1, 0, 0, 0);
        chk_all("open_done_tick", 0, 0, 0, 0, 0);

        // Manual relock with a simultaneous tick
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk_all("relock_pre", 1, 0, 0, 3, 0);
        cyc(1, 0, 0, 1);
        chk_all("relock", 0, 0, 0, 0, 0);

        // Lockout after three consecutive wrong codes
        cyc(0, 0, 1, 0);
        chk_all("bad1", 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0);
        chk_all("bad2", 0, 0, 0, 0, 2);
        cyc(0, 0, 1, 0);
        chk_all("penalty_entry", 0, 1, 1, 10, 0);
        cyc(0, 0, 0, 0);
        chk_all("alarm_single", 0, 1, 0, 10, 0);
        cyc(0, 1, 0, 0);
        chk_all("penalty_ok_ignored", 0, 1, 0, 10, 0);
        cyc(0, 0, 1, 1);
        chk_all("penalty_bad_rel_ignored", 0, 1, 0, 10, 0);
        for (int i = 1; i <= 9; i++) begin
            cyc(1, 0, 0, 0);
            cyc(0, 0, 0, 0);
        end
        chk_all("penalty_last_sec", 0, 1, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk_all("penalty_done", 0, 0, 0, 0, 0);

        // A correct code clears the failure count
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        chk("fail_two", int'(fail_cnt), 2);
        cyc(0, 1, 0, 0);
        chk_all("ok_clears_fail", 1, 0, 0, 5, 0);
        cyc(0, 0, 0, 1);
        chk_all("relock2", 0, 0, 0, 0, 0);

        // Simultaneous ok and bad counts as bad
        cyc(0, 1, 1, 0);
        chk_all("ok_bad_same", 0, 0, 0, 0, 1);

        // Entry coincident with a tick loads the full window
        cyc(1, 1, 0, 0);
        chk_all("entry_tick_open", 1, 0, 0, 5, 0);
        cyc(0, 0, 0, 1);

        // Penalty entry coincident with a tick, then reset mid-penalty
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 1, 0);
        chk_all("entry_tick_penalty", 0, 1, 1, 10, 0);
        repeat (4) cyc(1, 0, 0, 0);
        chk_all("penalty_six", 0, 1, 0, 6, 0);
        #2 clr = 1'b1;
        #1 chk_all("rst_mid_penalty", 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        clr = 1'b0;
        cyc(1, 0, 0, 0);
        chk_all("after_rst", 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
